udp_tx_arb: RTL and testbench
=============================

UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, meaning idle cycles enforced between consecutive packets.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning maximum BUSY cycles before a packet is abandoned.
REQ-003 gmii_txc  input  1  sole clock; all logic on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1 each  level request from channel 0 / 1 to send one packet.
REQ-006 mac0 / mac1  input  48 each  destination MAC for channel 0 / 1.
REQ-007 ip0 / ip1  input  32 each  destination IP for channel 0 / 1.
REQ-008 data0 / data1  input  16 each  payload word from channel 0 / 1.
REQ-009 grant0 / grant1  output  1 each  channel owns the UDP transmit engine.
REQ-010 data_req0 / data_req1  output  1 each  engine word strobe routed to the granted channel.
REQ-011 done0 / done1  output  1 each  one-cycle pulse: packet completed normally.
REQ-012 err_timeout  output  1  one-cycle pulse: packet abandoned on timeout.
REQ-013 udp_tx_en  output  1  one-cycle start pulse to the transmit engine.
REQ-014 udp_tx_data  output  16  payload word to the engine.
REQ-015 des_mac / des_ip  output  48 / 32  destination address to the engine.
REQ-016 udp_data_en  input  1  engine requests the next payload word.
REQ-017 udp_tx_done  input  1  engine finished the frame, including CRC.

Function
REQ-018 FSM states SHALL be IDLE, START, BUSY, GAP.
REQ-019 IDLE transitions:
- no request: stay in IDLE.
- one request: grant that channel.
- both requests: grant the channel not served last (round-robin pointer).
- always: on the grant edge, latch that channel's mac/ip into des_mac/des_ip and go to START.
REQ-020 START SHALL assert udp_tx_en for exactly one cycle, then go to BUSY.
REQ-021 grantN SHALL be high from START entry through the last BUSY cycle; never both grants high.
REQ-022 In START and BUSY:
- data_reqN = udp_data_en & grantN; the other data_req stays 0.
- udp_tx_data = dataN of the granted channel, combinationally; 0 in IDLE and GAP.
REQ-023 des_mac/des_ip SHALL stay constant from the latch edge until the next grant, whatever mac/ip do.
REQ-024 BUSY with udp_tx_done=1 SHALL:
- pulse doneN for one cycle;
- set the pointer to the channel just served;
- clear grants next cycle;
- go to GAP.
REQ-025 BUSY SHALL count cycles; at count = TIMEOUT_CYCLES-1 without udp_tx_done it SHALL:
- pulse err_timeout, with no done pulse;
- update the pointer as in REQ-024;
- go to GAP.
REQ-026 udp_tx_done and the timeout on the same cycle SHALL be treated as normal completion: done pulse, no err_timeout.
REQ-027 GAP SHALL last exactly IFG_CYCLES cycles, then return to IDLE; IFG_CYCLES=0 SHALL go straight to IDLE.
REQ-028 udp_tx_done or udp_data_en outside BUSY SHALL be ignored; no pulses.
REQ-029 A req dropped after grant SHALL NOT abort the packet.
REQ-030 A req still high in IDLE after its done SHALL count as a new packet request.
REQ-031 Packet start latency: req rising in IDLE -> udp_tx_en high on the 2nd rising edge; grant visible after the 1st.

Reset
REQ-032 rstn low SHALL immediately:
- force IDLE;
- set the pointer so channel 0 wins the first tie;
- clear the BUSY and GAP counters;
- drive all outputs to 0, including des_mac, des_ip and udp_tx_data.
REQ-033 Reset mid-packet SHALL abandon the packet without a done or err_timeout pulse; operation resumes on the first edge after rstn rises.

Verification
REQ-034 Single request:
- stimulus: req0=1, mac0=48'h112233445566, ip0=32'hC0A80102, udp_tx_done after 20 cycles.
- response: grant0 after edge 1; udp_tx_en pulse after edge 2; des_mac/des_ip equal the inputs; done0 pulse; 12 GAP cycles before the next grant.
REQ-035 Tie and rotation:
- stimulus: req0=req1=1 held continuously, from reset.
- response: grant order 0,1,0,1; each packet separated by exactly IFG_CYCLES idle cycles.
REQ-036 Data routing:
- stimulus: data0=16'hA5A5, data1=16'h5A5A, channel 1 granted, udp_data_en toggling.
- response: udp_tx_data=16'h5A5A; data_req1 follows udp_data_en; data_req0 stays 0.
REQ-037 Timeout:
- stimulus: TIMEOUT_CYCLES=100, no udp_tx_done.
- response: err_timeout pulse on the 100th BUSY cycle; no done; next grant after GAP.
- also: udp_tx_done on that same cycle gives a done pulse and no err_timeout.
REQ-038 Reset mid-BUSY:
- stimulus: rstn low during BUSY.
- response: all outputs 0 asynchronously; no pulses; after release, a pending req1 together with req0 gives grant0 first.

Source files
------------

// File: rtl/udp_tx_arb_if.sv
// Engine-side bundle between the two-channel arbiter and the UDP transmit engine.
interface udp_tx_arb_if;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        udp_data_en;
    logic        udp_tx_done;

    modport master (
        output udp_tx_en, udp_tx_data, des_mac, des_ip,
        input  udp_data_en, udp_tx_done
    );

    modport slave (
        input  udp_tx_en, udp_tx_data, des_mac, des_ip,
        output udp_data_en, udp_tx_done
    );
endinterface

// File: rtl/udp_tx_arb.sv
// Round-robin arbiter giving two packet sources turns at one UDP transmit engine,
// with a busy timeout and an enforced inter-frame gap.
module udp_tx_arb #(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          gmii_txc,
    input  logic          rstn,
    input  logic          req0,
    input  logic          req1,
    input  logic [47:0]   mac0,
    input  logic [47:0]   mac1,
    input  logic [31:0]   ip0,
    input  logic [31:0]   ip1,
    input  logic [15:0]   data0,
    input  logic [15:0]   data1,
    output logic          grant0,
    output logic          grant1,
    output logic          data_req0,
    output logic          data_req1,
    output logic          done0,
    output logic          done1,
    output logic          err_timeout,
    udp_tx_arb_if.master  eng
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0] BUSY_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t        state_q, state_d;
    logic          ch_q, ch_d;
    logic          ptr_q, ptr_d;
    logic          txEn_q, txEn_d;
    logic [47:0]   mac_q, mac_d;
    logic [31:0]   ip_q, ip_d;
    logic [CW-1:0] busyCnt_q, busyCnt_d;
    logic [GW-1:0] gapCnt_q, gapCnt_d;
    logic          owning;
    logic          endPkt;

    // ptr_q holds the last channel served; resetting it to 1 lets channel 0 win the first tie.
    always_ff @(posedge gmii_txc or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            ptr_q     <= 1'b1;
            txEn_q    <= 1'b0;
            mac_q     <= '0;
            ip_q      <= '0;
            busyCnt_q <= '0;
            gapCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            txEn_q    <= txEn_d;
            mac_q     <= mac_d;
            ip_q      <= ip_d;
            busyCnt_q <= busyCnt_d;
            gapCnt_q  <= gapCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        txEn_d      = 1'b0;
        mac_d       = mac_q;
        ip_d        = ip_q;
        busyCnt_d   = busyCnt_q;
        gapCnt_d    = gapCnt_q;
        done0       = 1'b0;
        done1       = 1'b0;
        err_timeout = 1'b0;
        endPkt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    ch_d    = (req0 && req1) ? ~ptr_q : req1;
                    mac_d   = ch_d ? mac1 : mac0;
                    ip_d    = ch_d ? ip1 : ip0;
                    state_d = START;
                end
            end
            START: begin
                txEn_d    = 1'b1;
                busyCnt_d = '0;
                state_d   = BUSY;
            end
            BUSY: begin
                // Completion wins over a timeout landing on the same cycle.
                if (eng.udp_tx_done) begin
                    done0  = ~ch_q;
                    done1  = ch_q;
                    endPkt = 1'b1;
                end else if (busyCnt_q == BUSY_LAST) begin
                    err_timeout = 1'b1;
                    endPkt      = 1'b1;
                end else begin
                    busyCnt_d = busyCnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    gapCnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (endPkt) begin
            ptr_d     = ch_q;
            busyCnt_d = '0;
            gapCnt_d  = '0;
            state_d   = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
    end

    assign owning          = (state_q == START) || (state_q == BUSY);
    assign grant0          = owning && !ch_q;
    assign grant1          = owning && ch_q;
    assign data_req0       = grant0 && eng.udp_data_en;
    assign data_req1       = grant1 && eng.udp_data_en;
    assign eng.udp_tx_data = owning ? (ch_q ? data1 : data0) : 16'h0000;
    assign eng.udp_tx_en   = txEn_q;
    assign eng.des_mac     = mac_q;
    assign eng.des_ip      = ip_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed and randomized packet sequences for udp_tx_arb, checked against a
// transaction-level round-robin model that predicts grant order and cycle timing.
module tb_udp_tx_arb;

    localparam int IFG = 12;
    localparam int TO  = 100;

    logic        gmii_txc = 1'b0;
    logic        rstn;
    logic        req0, req1;
    logic [47:0] mac0, mac1;
    logic [31:0] ip0, ip1;
    logic [15:0] data0, data1;
    logic        grant0, grant1, data_req0, data_req1, done0, done1, err_timeout;

    udp_tx_arb_if eng();

    udp_tx_arb #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)) dut (
        .gmii_txc    (gmii_txc),
        .rstn        (rstn),
        .req0        (req0),
        .req1        (req1),
        .mac0        (mac0),
        .mac1        (mac1),
        .ip0         (ip0),
        .ip1         (ip1),
        .data0       (data0),
        .data1       (data1),
        .grant0      (grant0),
        .grant1      (grant1),
        .data_req0   (data_req0),
        .data_req1   (data_req1),
        .done0       (done0),
        .done1       (done1),
        .err_timeout (err_timeout),
        .eng         (eng.master)
    );

    always #5 gmii_txc = ~gmii_txc;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int lastServed = 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge gmii_txc);
        #2;
    endtask

    // Per-cycle engine/source activity; fixData pins the payload words to known patterns.
    task automatic applyStimulus(input bit den, input bit done, input bit fixData);
        eng.udp_data_en = den;
        eng.udp_tx_done = done;
        data0 = fixData ? 16'hA5A5 : 16'($urandom);
        data1 = fixData ? 16'h5A5A : 16'($urandom);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_grant0"}, grant0, 0);
        checkOutput({tag, "_grant1"}, grant1, 0);
        checkOutput({tag, "_dreq0"}, data_req0, 0);
        checkOutput({tag, "_dreq1"}, data_req1, 0);
        checkOutput({tag, "_done"}, {done0, done1}, 0);
        checkOutput({tag, "_err"}, err_timeout, 0);
        checkOutput({tag, "_txen"}, eng.udp_tx_en, 0);
        checkOutput({tag, "_txdata"}, eng.udp_tx_data, 0);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkQuiet("rst");
        checkOutput("rst_mac", eng.des_mac, 0);
        checkOutput("rst_ip", eng.des_ip, 0);
        repeat (2) begin
            tick();
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkQuiet("rst_hold");
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        eng.udp_tx_done = 1'b0;
        eng.udp_data_en = 1'b0;
        rstn = 1'b1;
        lastServed = 1;
        #1;
    endtask

    task automatic idleCycles(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) begin
            tick();
            applyStimulus(1'($urandom), 1'($urandom), 1'b0);
            checkQuiet("idle");
        end
    endtask

    // Entered during an IDLE cycle; leaves during the IDLE cycle that follows the gap.
    task automatic runPacket(input bit r0, input bit r1, input int doneAt, input bit dropReq, input bit fixData);
        int ch;
        logic [47:0] expMac;
        logic [31:0] expIp;
        logic [15:0] expData;
        bit den;
        bit fin;
        ch     = (r0 && r1) ? 1 - lastServed : (r0 ? 0 : 1);
        expMac = (ch == 1) ? mac1 : mac0;
        expIp  = (ch == 1) ? ip1 : ip0;
        req0 = r0;
        req1 = r1;

        tick();
        if (dropReq) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        mac0 = {16'($urandom), 32'($urandom)};
        mac1 = {16'($urandom), 32'($urandom)};
        ip0  = 32'($urandom);
        ip1  = 32'($urandom);
        den  = 1'($urandom);
        applyStimulus(den, 1'($urandom), fixData);
        expData = (ch == 1) ? data1 : data0;
        checkOutput("start_grant0", grant0, (ch == 0));
        checkOutput("start_grant1", grant1, (ch == 1));
        checkOutput("start_txen", eng.udp_tx_en, 0);
        checkOutput("start_mac", eng.des_mac, expMac);
        checkOutput("start_ip", eng.des_ip, expIp);
        checkOutput("start_txdata", eng.udp_tx_data, expData);
        checkOutput("start_dreq", {data_req1, data_req0}, (ch == 1) ? {den, 1'b0} : {1'b0, den});
        checkOutput("start_done", {done0, done1, err_timeout}, 0);

        fin = 1'b0;
        for (int k = 1; !fin; k++) begin
            tick();
            mac0 = {16'($urandom), 32'($urandom)};
            ip1  = 32'($urandom);
            den  = 1'($urandom);
            applyStimulus(den, (k == doneAt), fixData);
            expData = (ch == 1) ? data1 : data0;
            checkOutput("busy_txen", eng.udp_tx_en, (k == 1));
            checkOutput("busy_grant", {grant1, grant0}, (ch == 1) ? 2'b10 : 2'b01);
            checkOutput("busy_dreq", {data_req1, data_req0}, (ch == 1) ? {den, 1'b0} : {1'b0, den});
            checkOutput("busy_txdata", eng.udp_tx_data, expData);
            checkOutput("busy_mac", eng.des_mac, expMac);
            checkOutput("busy_ip", eng.des_ip, expIp);
            checkOutput("busy_done0", done0, (k == doneAt) && (ch == 0));
            checkOutput("busy_done1", done1, (k == doneAt) && (ch == 1));
            checkOutput("busy_err", err_timeout, (k == TO) && (k != doneAt));
            fin = (k == doneAt) || (k == TO);
        end
        lastServed = ch;

        for (int g = 0; g < IFG; g++) begin
            tick();
            applyStimulus(1'($urandom), 1'($urandom), 1'b0);
            checkQuiet("gap");
            checkOutput("gap_mac", eng.des_mac, expMac);
        end
        tick();
        applyStimulus(1'($urandom), 1'($urandom), 1'b0);
        checkQuiet("rearb");
    endtask

    initial begin
        int r, sel, dAt;
        rstn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        mac0 = '0;
        mac1 = '0;
        ip0  = '0;
        ip1  = '0;
        data0 = '0;
        data1 = '0;
        eng.udp_data_en = 1'b0;
        eng.udp_tx_done = 1'b0;
        #3;
        doReset();

        mac0 = 48'h112233445566;
        ip0  = 32'hC0A80102;
        runPacket(1'b1, 1'b0, 20, 1'b1, 1'b0);
        idleCycles(3);

        doReset();
        repeat (4) runPacket(1'b1, 1'b1, 5 + int'($urandom_range(0, 10)), 1'b0, 1'b0);

        runPacket(1'b0, 1'b1, 8, 1'b1, 1'b1);

        runPacket(1'b1, 1'b0, 0, 1'b1, 1'b0);
        runPacket(1'b1, 1'b1, TO, 1'b0, 1'b0);
        idleCycles(2);

        for (int i = 0; i < 8; i++) begin
            r   = int'($urandom_range(1, 3));
            sel = int'($urandom_range(0, 5));
            dAt = (sel == 0) ? 0 : (sel == 1) ? TO : int'($urandom_range(1, 25));
            mac0 = {16'($urandom), 32'($urandom)};
            mac1 = {16'($urandom), 32'($urandom)};
            runPacket(1'(r), 1'(r >> 1), dAt, 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
        end

        idleCycles(1);
        req1 = 1'b1;
        tick();
        tick();
        tick();
        eng.udp_tx_done = 1'b0;
        doReset();
        runPacket(1'b1, 1'b1, 4, 1'b0, 1'b0);
        runPacket(1'b1, 1'b1, 4, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
